// File: rtl/tcp_net_pkg.sv
// Shared types and constants for the TCP network channel model.
//   snd_state_t : delivery FSM states
//   DROP_SAT    : saturation value of the drop counter
package tcp_net_pkg;

  typedef enum logic [0:0] {
    SND_IDLE  = 1'b0,
    SND_WRITE = 1'b1
  } snd_state_t;

  localparam logic [7:0] DROP_SAT = 8'hFF;

endpackage

// File: rtl/net_slot_pick.sv
// Lowest-set-bit priority encoder over the packet slot vector.
//   req   : one request bit per slot
//   found : at least one request bit set
//   idx   : index of the lowest set bit (0 when none)
module net_slot_pick #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic [DEPTH-1:0] req,
  output logic             found,
  output logic [AW-1:0]    idx
);

  always_comb begin
    found = |req;
    idx   = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req[i]) idx = AW'(i);
    end
  end

endmodule

// File: rtl/tcp_net_channel.sv
// Lossy, reordering network between sender and receiver protocol engines.
// All nondeterminism enters on oracle inputs.
//   clk, rst            : clock, synchronous active-high reset
//   val, data1, data2   : packet offered by the sender
//   rcv_go, drop        : oracles: sample the offer / discard it
//   acc                 : offer consumed this cycle (combinational)
//   snd_go, out_sel     : oracles: start a delivery / slot to deliver
//   rdy_b               : receiver takes the delivered packet
//   val_b, data1_b/2_b  : delivered packet (registered)
//   count, drops, ovf   : occupancy, saturating drop count, sticky overflow
module tcp_net_channel
  import tcp_net_pkg::*;
#(
  parameter int DW      = 4,
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int LOSSY   = 1,
  parameter int REORDER = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          val,
  input  logic [DW-1:0] data1,
  input  logic [DW-1:0] data2,
  input  logic          rcv_go,
  input  logic          drop,
  output logic          acc,
  input  logic          snd_go,
  input  logic [AW-1:0] out_sel,
  input  logic          rdy_b,
  output logic          val_b,
  output logic [DW-1:0] data1_b,
  output logic [DW-1:0] data2_b,
  output logic [AW:0]   count,
  output logic [7:0]    drops,
  output logic          ovf
);

  logic [DEPTH-1:0] valid;
  logic [DW-1:0]    d1 [DEPTH];
  logic [DW-1:0]    d2 [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, fly_idx;
  snd_state_t       state, state_nx;

  logic          full, do_drop, do_store, slot_ok;
  logic          free_found, vld_found, sel_ok, load, release_slot;
  logic [AW-1:0] free_idx, vld_idx, store_idx, sel_idx;

  net_slot_pick #(.DEPTH(DEPTH), .AW(AW)) u_free_pick (
    .req(~valid), .found(free_found), .idx(free_idx)
  );

  net_slot_pick #(.DEPTH(DEPTH), .AW(AW)) u_valid_pick (
    .req(valid), .found(vld_found), .idx(vld_idx)
  );

  assign full      = (count == (AW+1)'(DEPTH));
  assign acc       = val && rcv_go && !full;
  assign do_drop   = acc && drop && (LOSSY != 0);
  // The in-flight slot stays valid until rdy_b, so the free picker never
  // hands it out; a slot freed this cycle only shows as free next cycle.
  assign slot_ok   = (REORDER != 0) ? free_found : 1'b1;
  assign do_store  = acc && !do_drop && slot_ok;
  assign store_idx = (REORDER != 0) ? free_idx : wr_ptr;

  assign sel_idx = (REORDER != 0) ? (valid[out_sel] ? out_sel : vld_idx) : rd_ptr;
  assign sel_ok  = (REORDER != 0) ? vld_found : (count != '0);

  always_comb begin
    state_nx     = state;
    load         = 1'b0;
    release_slot = 1'b0;
    unique case (state)
      SND_IDLE: begin
        if (snd_go && sel_ok) begin
          load     = 1'b1;
          state_nx = SND_WRITE;
        end
      end
      SND_WRITE: begin
        if (rdy_b) begin
          release_slot = 1'b1;
          state_nx     = SND_IDLE;
        end
      end
      default: state_nx = SND_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SND_IDLE;
      valid   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      fly_idx <= '0;
      count   <= '0;
      drops   <= '0;
      ovf     <= 1'b0;
      val_b   <= 1'b0;
      data1_b <= '0;
      data2_b <= '0;
    end else begin
      state <= state_nx;

      if (do_store) begin
        valid[store_idx] <= 1'b1;
        wr_ptr           <= wr_ptr + AW'(1);
      end

      if (do_drop && drops != DROP_SAT) drops <= drops + 8'd1;
      if (val && rcv_go && full) ovf <= 1'b1;

      unique case ({do_store, release_slot})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase

      if (load) begin
        val_b   <= 1'b1;
        fly_idx <= sel_idx;
        data1_b <= d1[sel_idx];
        data2_b <= d2[sel_idx];
      end

      if (release_slot) begin
        valid[fly_idx] <= 1'b0;
        if (REORDER == 0) rd_ptr <= rd_ptr + AW'(1);
        val_b   <= 1'b0;
        data1_b <= '0;
        data2_b <= '0;
      end
    end
  end

  // Payload storage needs no reset: a slot is only read after it is written.
  always_ff @(posedge clk) begin
    if (do_store) begin
      d1[store_idx] <= data1;
      d2[store_idx] <= data2;
    end
  end

endmodule
